uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  User-project UART receiver, the device end of the link the testbench UART drives on mprj_io[5].
//  Deserialises 8N1 frames (LSB first, no parity), checks the stop bit and buffers good bytes in a small FIFO.
//  Firmware drains the FIFO over the user-project bus glue via a read-strobe handshake.
//  Exposes sticky frame and overrun errors plus a level interrupt.
// PARAMETERS
//  CLKS_PER_BIT  434  wb_clk_i cycles per bit period; must be >= 4.
//  FIFO_DEPTH    4    entries; power of two, >= 2.
// PORTS
//  wb_clk_i      in   1   single clock; all logic on rising edge.
//  wb_rst_i      in   1   synchronous, active-high reset.
//  rx_i          in   1   serial line, asynchronous, idle high.
//  rd_en_i       in   1   pop strobe: one byte per asserted cycle.
//  err_clr_i     in   1   clears frame_err_o and overrun_o.
//  rx_data_o     out  8   FIFO head (show-ahead); valid when rx_valid_o=1.
//  rx_valid_o    out  1   FIFO not empty.
//  fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current occupancy.
//  frame_err_o   out  1   sticky: a frame had stop bit = 0.
//  overrun_o     out  1   sticky: a good byte was dropped because the FIFO was full.
//  irq_o         out  1   rx_valid_o | frame_err_o | overrun_o (registered).
// BEHAVIOUR
//  Reset
//   - Reset is synchronous: wb_rst_i sampled high on an edge.
//   - Outputs: rx_data_o=0, rx_valid_o=0, level=0, errors=0, irq_o=0.
//   - FSM=IDLE; both synchroniser flops=1.
//   - Asserting reset mid-frame aborts the frame; FIFO contents are discarded.
//  Input path
//   - rx_i passes through a 2-flop synchroniser giving rx_s, plus one history flop rx_d.
//  Start detect
//   - Falling edge only (rx_d=1, rx_s=0).
//   - A line held low (break, or after a framing error) never re-triggers.
//  FSM (bit counter 0..CLKS_PER_BIT-1, data index 0..7)
//   - IDLE:  on start edge, clear the counter and go to START.
//   - START: at count = CLKS_PER_BIT/2 - 1, sample rx_s.
//       rx_s=1 -> false start, go to IDLE, nothing logged.
//       rx_s=0 -> clear the counter and go to DATA.
//   - DATA:  at count = CLKS_PER_BIT-1, shift rx_s into shreg[7] (LSB lands at [0] after 8 samples).
//       After the 8th sample, go to STOP.
//   - STOP:  at count = CLKS_PER_BIT-1, sample rx_s.
//       1 -> push shreg.  0 -> set frame_err_o, no push.
//       Then IDLE.
//  Push / pop
//   - Latency: the byte is visible on rx_data_o with rx_valid_o=1 exactly one cycle after the stop sample.
//   - rd_en_i while empty: ignored; no underflow, level stays 0.
//   - Push and pop in the same cycle: level unchanged; head advances; new byte written at tail.
//     This includes the full case, which gives no overrun.
//   - Push while full without pop: byte dropped, overrun_o=1, FIFO contents unchanged.
//   - Pointers wrap modulo FIFO_DEPTH; full/empty are derived from level.
//  Error flags
//   - err_clr_i clears both flags.
//   - A new error event in the same cycle as err_clr_i wins: the flag ends set.
//  irq_o: registered, so it follows its sources by one cycle.
// STRUCTURE
//  uart_pkg
//   - rx_state_e {IDLE, START, DATA, STOP}
//   - DATA_BITS=8
//  Sub-module sync_fifo #(WIDTH=8, DEPTH)
//   - Ports: push, pop, din, dout (show-ahead), level, full, empty.
//  uart_rx_fifo holds the synchroniser, the FSM, the counters and the error flags.
// TESTING (bench sets CLKS_PER_BIT=16, drives rx_i bit-serially)
//  1. Reset, send 0x3D (61) -> after stop sample + 1 cycle: rx_data_o=0x3D, rx_valid_o=1, level=1, irq_o=1 one cycle later.
//  2. Send 61,15,18,55 back-to-back, then pop four times -> reads 0x3D,0x0F,0x12,0x37 in order; level 0; rx_valid_o=0.
//  3. 8-cycle low glitch on idle line -> no push, FSM back in IDLE, no errors.
//  4. Send 0xA5 with stop=0 -> frame_err_o=1, level 0; hold the line low 3 bit times, no new frame.
//     Then err_clr_i -> flag cleared.
//  5. Send 5 bytes without popping (depth 4) -> level=4, overrun_o=1, head = first byte.
//     Repeat with rd_en_i pulsed on the 5th push cycle -> no overrun, level stays 4.
//  6. Assert wb_rst_i at DATA bit 3 with FIFO level 2 -> next cycle: all outputs 0.
//     A subsequent clean 0x55 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;
  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; occupancy is tracked explicitly and full/empty derive from it.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] DEPTH_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == DEPTH_LVL);
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; the pointers and level define which entries are live,
  // and dout is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with stop-bit check, byte FIFO, sticky error flags and a level interrupt.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          rx_i,
  input  logic                          rd_en_i,
  input  logic                          err_clr_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  output logic                          irq_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  rx_state_e              state;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   rx_meta;
  logic                   rx_s;
  logic                   rx_d;
  logic                   stop_tick;
  logic                   push;
  logic                   frame_evt;
  logic                   overrun_evt;
  logic                   fifo_full;
  logic                   fifo_empty;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        // Only a 1->0 transition starts a frame, so a stuck-low line never re-triggers.
        IDLE: if (rx_d && !rx_s) begin
          cnt   <= '0;
          state <= START;
        end
        START: if (cnt == HALF_END) begin
          cnt   <= '0;
          idx   <= '0;
          state <= rx_s ? IDLE : DATA;
        end else begin
          cnt <= cnt + CW'(1);
        end
        DATA: if (cnt == BIT_END) begin
          cnt   <= '0;
          shreg <= {rx_s, shreg[DATA_BITS-1:1]};
          if (idx == IDX_LAST) state <= STOP;
          else                 idx   <= idx + IW'(1);
        end else begin
          cnt <= cnt + CW'(1);
        end
        STOP: if (cnt == BIT_END) begin
          cnt   <= '0;
          state <= IDLE;
        end else begin
          cnt <= cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The stop sample pushes directly so the byte lands in the FIFO on that same edge.
  assign stop_tick   = (state == STOP) && (cnt == BIT_END);
  assign push        = stop_tick & rx_s;
  assign frame_evt   = stop_tick & ~rx_s;
  assign overrun_evt = push & fifo_full & ~rd_en_i;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push),
    .pop   (rd_en_i),
    .din   (shreg),
    .dout  (rx_data_o),
    .level (fifo_level_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid_o = ~fifo_empty;

  // A new error event takes priority over a clear in the same cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      irq_o       <= 1'b0;
    end else begin
      if (frame_evt)      frame_err_o <= 1'b1;
      else if (err_clr_i) frame_err_o <= 1'b0;
      if (overrun_evt)    overrun_o   <= 1'b1;
      else if (err_clr_i) overrun_o   <= 1'b0;
      irq_o <= rx_valid_o | frame_err_o | overrun_o;
    end
  end
endmodule
